// File: rtl/mem_rsp_tag_demux.sv
// mem_rsp_tag_demux: return path of the L1->L2 request arbiter.
// Strips the source-select field from the L2 response tag and steers each
// response into a 2-entry elastic buffer per L1 output. Out-of-range selects
// are accepted, discarded and counted.
module mem_rsp_tag_demux #(
  parameter  int NUM_OUTPUTS   = 5,
  parameter  int DATA_WIDTH    = 512,
  parameter  int TAG_OUT_WIDTH = 12,
  localparam int SEL_BITS      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 0,
  localparam int TAG_IN_WIDTH  = TAG_OUT_WIDTH + SEL_BITS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 mem_rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]                mem_rsp_data_in,
  input  logic [TAG_IN_WIDTH-1:0]              mem_rsp_tag_in,
  output logic                                 mem_rsp_ready_in,
  output logic [NUM_OUTPUTS-1:0]               mem_rsp_valid_out,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]    mem_rsp_data_out,
  output logic [NUM_OUTPUTS*TAG_OUT_WIDTH-1:0] mem_rsp_tag_out,
  input  logic [NUM_OUTPUTS-1:0]               mem_rsp_ready_out,
  output logic [15:0]                          drop_count,
  output logic                                 drop_pulse
);

  // Internal select width never collapses to zero so a single-output build
  // still has a legal index signal.
  localparam int SEL_W = (SEL_BITS > 0) ? SEL_BITS : 1;

  logic [SEL_W-1:0]         sel;
  logic [TAG_OUT_WIDTH-1:0] fwd_tag;
  logic                     sel_legal;
  logic                     push;
  logic [NUM_OUTPUTS-1:0]   push_hit;
  logic [NUM_OUTPUTS-1:0]   pop;

  logic [1:0]               count    [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0]   wr_ptr;
  logic [NUM_OUTPUTS-1:0]   rd_ptr;
  logic [DATA_WIDTH-1:0]    data_mem [NUM_OUTPUTS][2];
  logic [TAG_OUT_WIDTH-1:0] tag_mem  [NUM_OUTPUTS][2];

  generate
    if (NUM_OUTPUTS == 1) begin : g_single
      assign sel       = '0;
      assign fwd_tag   = mem_rsp_tag_in;
      assign sel_legal = 1'b1;
    end else begin : g_multi
      assign sel       = mem_rsp_tag_in[SEL_BITS-1:0];
      assign fwd_tag   = mem_rsp_tag_in[TAG_IN_WIDTH-1:SEL_BITS];
      assign sel_legal = (32'(sel) < NUM_OUTPUTS);
    end
  endgenerate

  // Ready looks only at the selected buffer's registered fill level, so a
  // same-cycle pop never opens the door and ready_out never reaches ready_in.
  always_comb begin
    mem_rsp_ready_in = 1'b1;
    if (sel_legal) begin
      mem_rsp_ready_in = (count[sel] != 2'd2);
    end
  end

  assign push = mem_rsp_valid_in & mem_rsp_ready_in & sel_legal;
  assign pop  = mem_rsp_valid_out & mem_rsp_ready_out;

  // One-hot decode of which output buffer receives this cycle's response.
  always_comb begin
    push_hit = '0;
    if (push) begin
      push_hit[sel] = 1'b1;
    end
  end

  // Fill level and pointers for every output buffer; push+pop keeps the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        count[i] <= 2'd0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (push_hit[i] && !pop[i]) begin
          count[i] <= count[i] + 2'd1;
        end else if (!push_hit[i] && pop[i]) begin
          count[i] <= count[i] - 2'd1;
        end
        if (push_hit[i]) begin
          wr_ptr[i] <= ~wr_ptr[i];
        end
        if (pop[i]) begin
          rd_ptr[i] <= ~rd_ptr[i];
        end
      end
    end
  end

  // Payload storage needs no reset: an empty buffer's slot contents are never shown as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[sel][wr_ptr[sel]] <= mem_rsp_data_in;
      tag_mem[sel][wr_ptr[sel]]  <= fwd_tag;
    end
  end

  // Each output presents the entry at its read pointer whenever it holds data.
  always_comb begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      mem_rsp_valid_out[i] = (count[i] != 2'd0);
      mem_rsp_data_out[i*DATA_WIDTH +: DATA_WIDTH]       = data_mem[i][rd_ptr[i]];
      mem_rsp_tag_out[i*TAG_OUT_WIDTH +: TAG_OUT_WIDTH]  = tag_mem[i][rd_ptr[i]];
    end
  end

  generate
    if (NUM_OUTPUTS > 1) begin : g_drop
      logic drop_fire;
      assign drop_fire = mem_rsp_valid_in & ~sel_legal;

      // Count and flag responses whose select names no real output; the count sticks at all-ones.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          drop_count <= 16'd0;
          drop_pulse <= 1'b0;
        end else begin
          drop_pulse <= drop_fire;
          if (drop_fire && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
          end
        end
      end
    end else begin : g_nodrop
      assign drop_count = 16'd0;
      assign drop_pulse = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_rsp_tag_demux.sv
// Testbench for mem_rsp_tag_demux: per-output expected queues filled by the
// stimulus side, drained and compared by an independent negedge monitor.
module tb_mem_rsp_tag_demux;

  localparam int NO  = 5;
  localparam int DW  = 512;
  localparam int TW  = 12;
  localparam int TIW = 15;

  logic              clk;
  logic              reset;
  logic              mem_rsp_valid_in;
  logic [DW-1:0]     mem_rsp_data_in;
  logic [TIW-1:0]    mem_rsp_tag_in;
  logic              mem_rsp_ready_in;
  logic [NO-1:0]     mem_rsp_valid_out;
  logic [NO*DW-1:0]  mem_rsp_data_out;
  logic [NO*TW-1:0]  mem_rsp_tag_out;
  logic [NO-1:0]     mem_rsp_ready_out;
  logic [15:0]       drop_count;
  logic              drop_pulse;

  mem_rsp_tag_demux #(.NUM_OUTPUTS(NO), .DATA_WIDTH(DW), .TAG_OUT_WIDTH(TW)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_rsp_valid_in  (mem_rsp_valid_in),
    .mem_rsp_data_in   (mem_rsp_data_in),
    .mem_rsp_tag_in    (mem_rsp_tag_in),
    .mem_rsp_ready_in  (mem_rsp_ready_in),
    .mem_rsp_valid_out (mem_rsp_valid_out),
    .mem_rsp_data_out  (mem_rsp_data_out),
    .mem_rsp_tag_out   (mem_rsp_tag_out),
    .mem_rsp_ready_out (mem_rsp_ready_out),
    .drop_count        (drop_count),
    .drop_pulse        (drop_pulse)
  );

  // 10-unit clock: posedges at 5, 15, ...; negedges at 10, 20, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected contents of each output buffer, {tag, data}, oldest first.
  logic [TW+DW-1:0] q [NO][$];
  logic [15:0]      exp_drop;
  logic             exp_pulse;
  logic [NO-1:0]    rdy;
  int               total;
  int               bad;

  logic [2:0]       mon_sel;
  logic             mon_ready;
  logic [NO-1:0]    mon_valid;
  logic [TW+DW-1:0] mon_front;

  task automatic checkOutput(input string name, input logic [527:0] act, input logic [527:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) begin
      d[w*32 +: 32] = $urandom;
    end
    return d;
  endfunction

  // One clock of stimulus: drive after the edge, decide acceptance just before the next one.
  task automatic applyStimulus(input logic v, input logic [TIW-1:0] tag, input logic [DW-1:0] data,
                               output logic acc);
    logic [2:0] s;
    @(posedge clk);
    #1;
    mem_rsp_valid_in  = v;
    mem_rsp_tag_in    = tag;
    mem_rsp_data_in   = data;
    mem_rsp_ready_out = rdy;
    #7;
    acc = v & mem_rsp_ready_in;
    s = tag[2:0];
    exp_pulse = 1'b0;
    if (acc) begin
      if (s < 3'd5) begin
        q[s].push_back({tag[TIW-1:3], data});
      end else begin
        exp_pulse = 1'b1;
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) applyStimulus(1'b0, mem_rsp_tag_in, mem_rsp_data_in, acc);
  endtask

  // Retry a response until accepted, with a bounded number of attempts.
  task automatic sendRsp(input logic [TIW-1:0] tag, input logic [DW-1:0] data);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      applyStimulus(1'b1, tag, data, acc);
      tries++;
    end
    if (!acc) checkOutput("send_timeout", 528'(acc), 528'(1));
  endtask

  // Monitor: ready, valid and drop outputs against the model; payload against queue heads.
  always @(negedge clk) begin
    if (!reset) begin
      mon_sel = mem_rsp_tag_in[2:0];
      if (mon_sel >= 3'd5) mon_ready = 1'b1;
      else                 mon_ready = (q[mon_sel].size() < 2);
      checkOutput("ready_in", 528'(mem_rsp_ready_in), 528'(mon_ready));
      for (int i = 0; i < NO; i++) mon_valid[i] = (q[i].size() != 0);
      checkOutput("valid_out", 528'(mem_rsp_valid_out), 528'(mon_valid));
      checkOutput("drop_count", 528'(drop_count), 528'(exp_drop));
      checkOutput("drop_pulse", 528'(drop_pulse), 528'(exp_pulse));
      for (int i = 0; i < NO; i++) begin
        if (mem_rsp_valid_out[i] && q[i].size() != 0) begin
          mon_front = q[i][0];
          checkOutput($sformatf("tag_out%0d", i), 528'(mem_rsp_tag_out[i*TW +: TW]),
                      528'(mon_front[TW+DW-1:DW]));
          checkOutput($sformatf("data_out%0d", i), 528'(mem_rsp_data_out[i*DW +: DW]),
                      528'(mon_front[DW-1:0]));
          if (mem_rsp_ready_out[i]) void'(q[i].pop_front());
        end
      end
    end
  end

  initial begin
    logic          acc;
    logic [2:0]    s;
    logic [DW-1:0] d0;
    int            guard;
    total = 0;
    bad = 0;
    exp_drop = 16'd0;
    exp_pulse = 1'b0;
    rdy = '1;
    reset = 1'b1;
    mem_rsp_valid_in = 1'b0;
    mem_rsp_tag_in = {12'h000, 3'd2};
    mem_rsp_data_in = '0;
    mem_rsp_ready_out = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid_out", 528'(mem_rsp_valid_out), 528'(0));
    checkOutput("rst_ready_in", 528'(mem_rsp_ready_in), 528'(1));
    checkOutput("rst_drop_count", 528'(drop_count), 528'(0));
    checkOutput("rst_drop_pulse", 528'(drop_pulse), 528'(0));
    reset = 1'b0;

    // Single response to output 1
    d0 = rand_data();
    applyStimulus(1'b1, {12'h5A3, 3'd1}, d0, acc);
    checkOutput("single_acc", 528'(acc), 528'(1));
    idle(3);

    // Backpressure on output 2
    rdy = 5'b11011;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, {12'(12'h200 + k), 3'd2}, rand_data(), acc);
      checkOutput("bp_acc", 528'(acc), 528'(1));
    end
    d0 = rand_data();
    applyStimulus(1'b1, {12'h2FF, 3'd2}, d0, acc);
    checkOutput("bp_full_blocked", 528'(acc), 528'(0));
    rdy = '1;
    applyStimulus(1'b1, {12'h2FF, 3'd2}, d0, acc);
    checkOutput("bp_pop_cycle_blocked", 528'(acc), 528'(0));
    applyStimulus(1'b1, {12'h2FF, 3'd2}, d0, acc);
    checkOutput("bp_after_pop_acc", 528'(acc), 528'(1));
    idle(4);

    // Isolation: output 0 stalled and full, output 3 streams
    rdy = 5'b11110;
    sendRsp({12'h010, 3'd0}, rand_data());
    sendRsp({12'h011, 3'd0}, rand_data());
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, {12'(12'h300 + k), 3'd3}, rand_data(), acc);
      checkOutput("iso_acc", 528'(acc), 528'(1));
    end
    rdy = '1;
    idle(4);

    // Illegal select and drop-count saturation
    applyStimulus(1'b1, {12'h0AB, 3'd6}, rand_data(), acc);
    checkOutput("drop_acc", 528'(acc), 528'(1));
    idle(1);
    checkOutput("drop_count_one", 528'(drop_count), 528'(1));
    guard = 0;
    while (exp_drop != 16'hFFFF && guard < 70000) begin
      applyStimulus(1'b1, {12'h0CD, 3'(5 + (guard % 3))}, mem_rsp_data_in, acc);
      guard++;
    end
    applyStimulus(1'b1, {12'h0CE, 3'd7}, mem_rsp_data_in, acc);
    idle(2);
    checkOutput("drop_sat", 528'(drop_count), 528'(16'hFFFF));

    // Simultaneous push and pop on output 4
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, {12'(12'h400 + k), 3'd4}, rand_data(), acc);
      checkOutput("pp_acc", 528'(acc), 528'(1));
    end
    idle(3);

    // Async reset with outputs 0 and 2 full
    rdy = 5'b11010;
    sendRsp({12'h020, 3'd0}, rand_data());
    sendRsp({12'h021, 3'd0}, rand_data());
    sendRsp({12'h022, 3'd2}, rand_data());
    sendRsp({12'h023, 3'd2}, rand_data());
    @(posedge clk);
    #3;
    reset = 1'b1;
    mem_rsp_valid_in = 1'b0;
    for (int i = 0; i < NO; i++) q[i].delete();
    exp_drop = 16'd0;
    exp_pulse = 1'b0;
    #1;
    checkOutput("arst_valid_out", 528'(mem_rsp_valid_out), 528'(0));
    checkOutput("arst_drop_count", 528'(drop_count), 528'(0));
    checkOutput("arst_ready_in", 528'(mem_rsp_ready_in), 528'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy = '1;
    idle(1);
    applyStimulus(1'b1, {12'h777, 3'd0}, rand_data(), acc);
    checkOutput("post_rst_acc", 528'(acc), 528'(1));
    idle(3);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NO; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      s = 3'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 9) < 6), {12'($urandom), s}, rand_data(), acc);
    end

    // Drain
    rdy = '1;
    idle(6);
    guard = 0;
    for (int i = 0; i < NO; i++) guard += q[i].size();
    checkOutput("drained", 528'(guard), 528'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
